prio_encoder_pipe: RTL and testbench



---
 rtl/prio_encoder_pipe.sv | 160 ++++++++++++++++
 tb/tb_prio_encoder_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/prio_encoder_pipe.sv
// prio_encoder_pipe
// Registered N-to-log2(N) priority encoder with valid/ready handshakes on
// both sides. Every accepted request vector becomes one output beat that
// carries the winning index, its one-hot grant, the popcount and an
// all-zero flag. MODE selects fixed priority (highest index wins) or
// round-robin arbitration starting from a rotating pointer.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   in_valid   req is valid this cycle
//   in_ready   block can accept req this cycle (only combinational output)
//   req        request vector, bit i = line i
//   out_valid  output register holds a result
//   out_ready  downstream consumes the result this cycle
//   out_idx    winning index (0 when out_none)
//   out_onehot one-hot of the winner (all-zero when out_none)
//   out_none   accepted req was all-zero
//   out_count  popcount of the accepted req
//
// state    | meaning
// ---------+---------------------------------------------
// ST_EMPTY | output register holds nothing, out_valid=0
// ST_FULL  | output register holds a result, out_valid=1

module prio_encoder_pipe #(
    parameter int N    = 4,
    parameter int MODE = 0,
    localparam int W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic         out_none,
    output logic [W:0]   out_count
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t       r_state;
    logic [W-1:0] r_idx;
    logic [N-1:0] r_onehot;
    logic         r_none;
    logic [W:0]   r_count;

    logic         w_accept;
    logic         w_any;
    logic [W-1:0] w_win_idx;
    logic [N-1:0] w_win_onehot;
    logic [W:0]   w_count;

    assign out_valid  = (r_state == ST_FULL);
    assign out_idx    = r_idx;
    assign out_onehot = r_onehot;
    assign out_none   = r_none;
    assign out_count  = r_count;

    // A consumed beat frees the register in the same cycle, so back-pressure
    // passes straight through and full throughput needs no skid buffer.
    assign in_ready = (r_state == ST_EMPTY) || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_any    = |req;

    always_comb begin
        w_count = '0;
        for (int i = 0; i < N; i++) begin
            w_count = w_count + (W+1)'(req[i]);
        end
    end

    generate
        if (MODE == 0) begin : g_fixed
            // Later iterations overwrite earlier ones: highest set bit wins.
            always_comb begin
                w_win_idx = '0;
                for (int i = 0; i < N; i++) begin
                    if (req[i]) begin
                        w_win_idx = W'(i);
                    end
                end
            end
        end else begin : g_rr
            logic [W-1:0] r_ptr;

            // Scan from r_ptr upward, wrapping at N (not 2^W).
            always_comb begin
                logic found;
                int   j;
                found     = 1'b0;
                j         = 0;
                w_win_idx = '0;
                for (int k = 0; k < N; k++) begin
                    j = int'(r_ptr) + k;
                    if (j >= N) begin
                        j = j - N;
                    end
                    if (!found && req[j]) begin
                        w_win_idx = W'(j);
                        found     = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ptr <= '0;
                end else if (w_accept && w_any) begin
                    r_ptr <= (w_win_idx == W'(N-1)) ? '0 : w_win_idx + 1'b1;
                end
            end
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_win_onehot[i] = w_any && (w_win_idx == W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_EMPTY;
            r_idx    <= '0;
            r_onehot <= '0;
            r_none   <= 1'b0;
            r_count  <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_ready && !w_accept) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase

            if (w_accept) begin
                r_idx    <= w_any ? w_win_idx : '0;
                r_onehot <= w_win_onehot;
                r_none   <= !w_any;
                r_count  <= w_count;
            end
        end
    end

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Bench for prio_encoder_pipe: three instances (N=4 fixed, N=4 round-robin,
// N=5 round-robin) share the handshake inputs. A behavioural model tracks
// each one and is compared every cycle; directed sequences add literal
// expectations, then a randomized phase runs against the model.

module tb_prio_encoder_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [3:0] req4;
    logic [4:0] req5;

    logic       fx_rdy, fx_val, fx_none;
    logic [1:0] fx_idx;
    logic [3:0] fx_oh;
    logic [2:0] fx_cnt;

    logic       r4_rdy, r4_val, r4_none;
    logic [1:0] r4_idx;
    logic [3:0] r4_oh;
    logic [2:0] r4_cnt;

    logic       r5_rdy, r5_val, r5_none;
    logic [2:0] r5_idx;
    logic [4:0] r5_oh;
    logic [3:0] r5_cnt;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    prio_encoder_pipe #(.N(4), .MODE(0)) u_fx (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(fx_rdy), .req(req4),
        .out_valid(fx_val), .out_ready(out_ready), .out_idx(fx_idx),
        .out_onehot(fx_oh), .out_none(fx_none), .out_count(fx_cnt));

    prio_encoder_pipe #(.N(4), .MODE(1)) u_r4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r4_rdy), .req(req4),
        .out_valid(r4_val), .out_ready(out_ready), .out_idx(r4_idx),
        .out_onehot(r4_oh), .out_none(r4_none), .out_count(r4_cnt));

    prio_encoder_pipe #(.N(5), .MODE(1)) u_r5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r5_rdy), .req(req5),
        .out_valid(r5_val), .out_ready(out_ready), .out_idx(r5_idx),
        .out_onehot(r5_oh), .out_none(r5_none), .out_count(r5_cnt));

    localparam int MN [3] = '{4, 4, 5};
    localparam int MM [3] = '{0, 1, 1};

    int m_valid [3];
    int m_idx   [3];
    int m_oh    [3];
    int m_none  [3];
    int m_cnt   [3];
    int m_ptr   [3];

    logic [31:0] act_rdy [3];
    logic [31:0] act_val [3];
    logic [31:0] act_idx [3];
    logic [31:0] act_oh  [3];
    logic [31:0] act_non [3];
    logic [31:0] act_cnt [3];

    always_comb begin
        act_rdy[0] = 32'(fx_rdy); act_val[0] = 32'(fx_val); act_idx[0] = 32'(fx_idx);
        act_oh[0]  = 32'(fx_oh);  act_non[0] = 32'(fx_none); act_cnt[0] = 32'(fx_cnt);
        act_rdy[1] = 32'(r4_rdy); act_val[1] = 32'(r4_val); act_idx[1] = 32'(r4_idx);
        act_oh[1]  = 32'(r4_oh);  act_non[1] = 32'(r4_none); act_cnt[1] = 32'(r4_cnt);
        act_rdy[2] = 32'(r5_rdy); act_val[2] = 32'(r5_val); act_idx[2] = 32'(r5_idx);
        act_oh[2]  = 32'(r5_oh);  act_non[2] = 32'(r5_none); act_cnt[2] = 32'(r5_cnt);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Winner from the arbitration rules: fixed = highest set line,
    // round-robin = first set line met walking up from ptr modulo n.
    function automatic int winner(input int r, input int n, input int mode, input int ptr);
        if (mode == 0) begin
            for (int i = n - 1; i >= 0; i--) if (((r >> i) & 1) == 1) return i;
        end else begin
            for (int k = 0; k < n; k++) if (((r >> ((ptr + k) % n)) & 1) == 1) return (ptr + k) % n;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            int r, w;
            bit acc;
            r = (d < 2) ? int'(req4) : int'(req5);
            if (rst) begin
                m_valid[d] = 0; m_idx[d] = 0; m_oh[d] = 0;
                m_none[d]  = 0; m_cnt[d] = 0; m_ptr[d] = 0;
            end else begin
                acc = in_valid && (m_valid[d] == 0 || out_ready);
                if (acc) begin
                    w = winner(r, MN[d], MM[d], m_ptr[d]);
                    m_valid[d] = 1;
                    m_none[d]  = (r == 0) ? 1 : 0;
                    m_idx[d]   = (r == 0) ? 0 : w;
                    m_oh[d]    = (r == 0) ? 0 : (1 << w);
                    m_cnt[d]   = $countones(r);
                    if (r != 0 && MM[d] == 1) m_ptr[d] = (w + 1) % MN[d];
                end else if (out_ready) begin
                    m_valid[d] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                check($sformatf("model d%0d in_ready", d), act_rdy[d],
                      32'((m_valid[d] == 0 || out_ready) ? 1 : 0));
                check($sformatf("model d%0d out_valid", d), act_val[d], 32'(m_valid[d]));
                check($sformatf("model d%0d out_idx", d), act_idx[d], 32'(m_idx[d]));
                check($sformatf("model d%0d out_onehot", d), act_oh[d], 32'(m_oh[d]));
                check($sformatf("model d%0d out_none", d), act_non[d], 32'(m_none[d]));
                check($sformatf("model d%0d out_count", d), act_cnt[d], 32'(m_cnt[d]));
            end
        end
    end

    // Apply inputs, let one rising edge pass, return 2 time units after it.
    task automatic cyc(input logic r, input logic iv, input logic [3:0] q4,
                       input logic [4:0] q5, input logic ordy);
        rst = r; in_valid = iv; req4 = q4; req5 = q5; out_ready = ordy;
        @(posedge clk);
        #2;
    endtask

    int exp_r4 [6] = '{0, 1, 2, 3, 0, 1};
    int exp_r5 [6] = '{0, 4, 0, 4, 0, 4};

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; req4 = '0; req5 = '0;
        cyc(1, 0, 4'b0000, 5'b00000, 1);
        chk_en = 1'b1;
        check("reset fx out_valid", 32'(fx_val), 0);
        check("reset r5 out_valid", 32'(r5_val), 0);
        check("reset fx in_ready", 32'(fx_rdy), 1);
        check("reset fx out_count", 32'(fx_cnt), 0);

        // fixed priority, one-hot inputs
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 4'(1 << i), 5'b10001, 1);
            check("basic fx out_idx", 32'(fx_idx), 32'(i));
            check("basic fx out_count", 32'(fx_cnt), 1);
            check("basic fx out_none", 32'(fx_none), 0);
        end
        cyc(0, 1, 4'b1011, 5'b10001, 1);
        check("fixed 1011 out_idx", 32'(fx_idx), 3);
        check("fixed 1011 out_onehot", 32'(fx_oh), 8);
        check("fixed 1011 out_count", 32'(fx_cnt), 3);
        cyc(0, 1, 4'b0000, 5'b10001, 1);
        check("zero fx out_none", 32'(fx_none), 1);
        check("zero fx out_idx", 32'(fx_idx), 0);
        check("zero fx out_count", 32'(fx_cnt), 0);
        check("zero fx out_valid", 32'(fx_val), 1);

        // round-robin sweep with wrap, N=4 and N=5
        cyc(1, 0, 4'b0000, 5'b00000, 1);
        check("rr reset out_valid", 32'(r4_val), 0);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 4'b1111, 5'b10001, 1);
            check("rr4 sweep out_idx", 32'(r4_idx), 32'(exp_r4[i]));
            check("rr5 sweep out_idx", 32'(r5_idx), 32'(exp_r5[i]));
        end
        cyc(0, 1, 4'b0101, 5'b10001, 1);
        check("rr4 0101 ptr2 out_idx", 32'(r4_idx), 2);
        cyc(0, 1, 4'b0101, 5'b10001, 1);
        check("rr4 0101 wrap out_idx", 32'(r4_idx), 0);

        // back-pressure: last result (idx 0) held while in_ready=0
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 4'b1111, 5'b10001, 0);
            check("stall r4 out_idx", 32'(r4_idx), 0);
            check("stall r4 out_valid", 32'(r4_val), 1);
            check("stall r4 in_ready", 32'(r4_rdy), 0);
        end
        cyc(0, 1, 4'b1111, 5'b10001, 1);
        check("release r4 out_idx", 32'(r4_idx), 1);
        check("release r4 out_valid", 32'(r4_val), 1);
        cyc(0, 0, 4'b1111, 5'b10001, 1);
        check("drain r4 out_valid", 32'(r4_val), 0);

        // reset mid-stream with ptr=3 and a pending result
        cyc(1, 0, 4'b0000, 5'b00000, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 4'b1111, 5'b10001, 1);
        check("pre-rst r4 out_idx", 32'(r4_idx), 2);
        cyc(1, 1, 4'b1111, 5'b10001, 1);
        check("mid rst r4 out_valid", 32'(r4_val), 0);
        check("mid rst r4 in_ready", 32'(r4_rdy), 1);
        cyc(0, 1, 4'b1111, 5'b10001, 1);
        check("post rst r4 out_idx", 32'(r4_idx), 0);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom),
                ($urandom_range(0, 7) == 0) ? 5'b00000 : 5'($urandom),
                ($urandom_range(0, 9) < 7));
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
